// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory, branch-predictor query, MEM redirect and IF/ID outputs.
interface fetch_unit_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] bp_fetch_pc;
  logic        bp_fetch_predict;
  logic [31:0] bp_fetch_target;
  logic        mem_flush;
  logic [31:0] mem_redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_predict;
  logic [31:0] if_target;

  modport master (
    output imem_ren, imem_addr, bp_fetch_pc,
           if_valid, if_instr, if_pc, if_predict, if_target,
    input  imem_ready, imem_rdata, bp_fetch_predict, bp_fetch_target,
           mem_flush, mem_redirect_pc, id_stall
  );

  modport slave (
    input  imem_ren, imem_addr, bp_fetch_pc,
           if_valid, if_instr, if_pc, if_predict, if_target,
    output imem_ready, imem_rdata, bp_fetch_predict, bp_fetch_target,
           mem_flush, mem_redirect_pc, id_stall
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem requests, redirect with stale-response drop,
// IF/ID latch backed by a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          nrst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {REQ, DROP, SKID} state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] drop_addr_reg;

  logic        if_valid_reg;
  logic [31:0] if_instr_reg;
  logic [31:0] if_pc_reg;
  logic        if_predict_reg;
  logic [31:0] if_target_reg;

  logic [31:0] skid_instr_reg;
  logic [31:0] skid_pc_reg;
  logic        skid_predict_reg;
  logic [31:0] skid_target_reg;

  logic        accept;
  logic [31:0] next_pc;
  logic [31:0] redirect_pc;
  logic        load_main;
  logic        load_skid;

  always_comb begin
    accept      = !if_valid_reg || !bus.id_stall;
    next_pc     = bus.bp_fetch_predict ? {bus.bp_fetch_target[31:2], 2'b00}
                                       : {pc_reg[31:2] + 30'd1, 2'b00};
    redirect_pc = {bus.mem_redirect_pc[31:2], 2'b00};
    load_main   = (state_reg == REQ) && bus.imem_ready && !bus.mem_flush && accept;
    load_skid   = (state_reg == SKID) && !bus.mem_flush && !bus.id_stall;
  end

  // A stale request keeps the bus on drop_addr so the address stays stable until ready.
  assign bus.imem_ren    = (state_reg != SKID);
  assign bus.imem_addr   = (state_reg == DROP) ? drop_addr_reg : pc_reg;
  assign bus.bp_fetch_pc = pc_reg;

  assign bus.if_valid   = if_valid_reg;
  assign bus.if_instr   = if_instr_reg;
  assign bus.if_pc      = if_pc_reg;
  assign bus.if_predict = if_predict_reg;
  assign bus.if_target  = if_target_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg        <= REQ;
      pc_reg           <= RESET_PC_W;
      drop_addr_reg    <= RESET_PC_W;
      if_valid_reg     <= 1'b0;
      if_instr_reg     <= '0;
      if_pc_reg        <= '0;
      if_predict_reg   <= 1'b0;
      if_target_reg    <= '0;
      skid_instr_reg   <= '0;
      skid_pc_reg      <= '0;
      skid_predict_reg <= 1'b0;
      skid_target_reg  <= '0;
    end else begin
      case (state_reg)
        REQ: begin
          if (bus.mem_flush) begin
            pc_reg <= redirect_pc;
            if (!bus.imem_ready) begin
              drop_addr_reg <= pc_reg;
              state_reg     <= DROP;
            end
          end else if (bus.imem_ready) begin
            pc_reg <= next_pc;
            if (!accept) begin
              skid_instr_reg   <= bus.imem_rdata;
              skid_pc_reg      <= pc_reg;
              skid_predict_reg <= bus.bp_fetch_predict;
              skid_target_reg  <= bus.bp_fetch_target;
              state_reg        <= SKID;
            end
          end
        end
        DROP: begin
          // A later flush only retargets pc; the outstanding stale response still ends DROP.
          if (bus.mem_flush)
            pc_reg <= redirect_pc;
          if (bus.imem_ready)
            state_reg <= REQ;
        end
        SKID: begin
          if (bus.mem_flush) begin
            pc_reg    <= redirect_pc;
            state_reg <= REQ;
          end else if (!bus.id_stall) begin
            state_reg <= REQ;
          end
        end
        default: state_reg <= REQ;
      endcase

      if (bus.mem_flush) begin
        if_valid_reg <= 1'b0;
      end else if (load_main) begin
        if_valid_reg   <= 1'b1;
        if_instr_reg   <= bus.imem_rdata;
        if_pc_reg      <= pc_reg;
        if_predict_reg <= bus.bp_fetch_predict;
        if_target_reg  <= bus.bp_fetch_target;
      end else if (load_skid) begin
        if_valid_reg   <= 1'b1;
        if_instr_reg   <= skid_instr_reg;
        if_pc_reg      <= skid_pc_reg;
        if_predict_reg <= skid_predict_reg;
        if_target_reg  <= skid_target_reg;
      end else if (!bus.id_stall) begin
        if_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: driver pushes hand-computed IF/ID entries, a monitor pops
// and compares each entry as decode consumes it.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        predict;
    logic [31:0] target;
  } entry_t;

  logic clk;
  logic nrst;
  fetch_unit_if bus ();

  int tests;
  int fails;
  entry_t exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.imem_rdata = instr_of(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    entry_t e;
    e.instr   = instr_of(pc);
    e.pc      = pc;
    e.predict = pred;
    e.target  = tgt;
    exp_q.push_back(e);
  endtask

  // Monitor: an entry is consumed when valid, not stalled and not squashed by a flush.
  always @(negedge clk) begin
    if (nrst && bus.if_valid && !bus.id_stall && !bus.mem_flush) begin
      entry_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected none", bus.if_pc, bus.if_instr);
      end else begin
        e = exp_q.pop_front();
        if (bus.if_instr !== e.instr || bus.if_pc !== e.pc ||
            bus.if_predict !== e.predict || bus.if_target !== e.target) begin
          fails++;
          $display("FAIL sb_entry: got {%h,%h,%b,%h} expected {%h,%h,%b,%h}",
                   bus.if_instr, bus.if_pc, bus.if_predict, bus.if_target,
                   e.instr, e.pc, e.predict, e.target);
        end else begin
          $display("ok   sb_entry pc=%h instr=%h pred=%b tgt=%h",
                   e.pc, e.instr, e.predict, e.target);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    nrst  = 1'b0;
    bus.imem_ready       = 1'b1;
    bus.bp_fetch_predict = 1'b0;
    bus.bp_fetch_target  = 32'h0;
    bus.mem_flush        = 1'b0;
    bus.mem_redirect_pc  = 32'h0;
    bus.id_stall         = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_if_valid",   {31'b0, bus.if_valid},   32'd0);
    chk("rst_if_instr",   bus.if_instr,            32'd0);
    chk("rst_if_pc",      bus.if_pc,               32'd0);
    chk("rst_if_predict", {31'b0, bus.if_predict}, 32'd0);
    chk("rst_if_target",  bus.if_target,           32'd0);
    chk("rst_imem_ren",   {31'b0, bus.imem_ren},   32'd1);
    chk("rst_imem_addr",  bus.imem_addr,           32'd0);
    nrst = 1'b1;

    // Streaming fetch with single-cycle memory
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", bus.imem_addr, 32'(4 * i));
      chk("seq_bp_pc", bus.bp_fetch_pc, 32'(4 * i));
      push(32'(4 * i), 1'b0, 32'h0);
      step();
      chk("seq_if_pc", bus.if_pc, 32'(4 * i));
      chk("seq_if_valid", {31'b0, bus.if_valid}, 32'd1);
    end

    // Predicted-taken branch at 0x10
    chk("br_addr", bus.imem_addr, 32'h10);
    bus.bp_fetch_predict = 1'b1;
    bus.bp_fetch_target  = 32'h40;
    push(32'h10, 1'b1, 32'h40);
    step();
    chk("br_next_addr", bus.imem_addr, 32'h40);
    chk("br_if_pc", bus.if_pc, 32'h10);
    chk("br_if_predict", {31'b0, bus.if_predict}, 32'd1);
    chk("br_if_target", bus.if_target, 32'h40);
    bus.bp_fetch_predict = 1'b0;
    bus.bp_fetch_target  = 32'h0;
    push(32'h40, 1'b0, 32'h0);
    step();
    chk("br_seq_addr", bus.imem_addr, 32'h44);
    // 0x44 is fetched but squashed by the coming flush, so it is never expected
    bus.bp_fetch_predict = 1'b1;
    bus.bp_fetch_target  = 32'h20;
    step();
    chk("br2_addr", bus.imem_addr, 32'h20);
    chk("br2_if_pc", bus.if_pc, 32'h44);
    bus.bp_fetch_predict = 1'b0;
    bus.bp_fetch_target  = 32'h0;

    // Memory wait with flush in its first cycle
    bus.imem_ready      = 1'b0;
    bus.mem_flush       = 1'b1;
    bus.mem_redirect_pc = 32'h100;
    step();
    bus.mem_flush = 1'b0;
    chk("drop_addr_c1", bus.imem_addr, 32'h20);
    chk("drop_valid_c1", {31'b0, bus.if_valid}, 32'd0);
    step();
    chk("drop_addr_c2", bus.imem_addr, 32'h20);
    step();
    chk("drop_addr_c3", bus.imem_addr, 32'h20);
    chk("drop_ren_c3", {31'b0, bus.imem_ren}, 32'd1);
    bus.imem_ready = 1'b1;
    step();
    chk("drop_redirect_addr", bus.imem_addr, 32'h100);
    chk("drop_valid_after", {31'b0, bus.if_valid}, 32'd0);
    push(32'h100, 1'b0, 32'h0);
    step();
    chk("post_drop_if_pc", bus.if_pc, 32'h100);

    // Decode stall two cycles: one response parked in the skid buffer
    bus.id_stall = 1'b1;
    step();
    chk("skid_ren_c1", {31'b0, bus.imem_ren}, 32'd0);
    chk("skid_hold_pc", bus.if_pc, 32'h100);
    step();
    chk("skid_ren_c2", {31'b0, bus.imem_ren}, 32'd0);
    bus.id_stall = 1'b0;
    push(32'h104, 1'b0, 32'h0);
    step();
    chk("skid_out_pc", bus.if_pc, 32'h104);
    chk("skid_resume_addr", bus.imem_addr, 32'h108);
    chk("skid_resume_ren", {31'b0, bus.imem_ren}, 32'd1);
    step();
    chk("skid_next_pc", bus.if_pc, 32'h108);

    // Flush while in SKID; 0x108 in the latch and 0x10c in the skid are both squashed
    bus.id_stall = 1'b1;
    step();
    chk("skid2_ren", {31'b0, bus.imem_ren}, 32'd0);
    bus.id_stall        = 1'b0;
    bus.mem_flush       = 1'b1;
    bus.mem_redirect_pc = 32'h200;
    step();
    bus.mem_flush = 1'b0;
    chk("skidflush_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("skidflush_addr", bus.imem_addr, 32'h200);
    chk("skidflush_ren", {31'b0, bus.imem_ren}, 32'd1);
    step();
    chk("skidflush_if_pc", bus.if_pc, 32'h200);

    // Enter DROP, then assert reset mid-cycle
    bus.imem_ready      = 1'b0;
    bus.mem_flush       = 1'b1;
    bus.mem_redirect_pc = 32'h300;
    step();
    bus.mem_flush = 1'b0;
    chk("drop2_addr", bus.imem_addr, 32'h204);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_if_pc", bus.if_pc, 32'h0);
    bus.imem_ready = 1'b1;
    step();
    chk("arst_stale_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("arst_stale_addr", bus.imem_addr, 32'h0);
    nrst = 1'b1;
    push(32'h0, 1'b0, 32'h0);
    step();
    chk("rel_if_pc", bus.if_pc, 32'h0);
    chk("rel_addr", bus.imem_addr, 32'h4);
    bus.imem_ready = 1'b0;
    step();
    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
